// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the IFU/LSU memory-port arbiter.
package mem_arbiter_pkg;

  localparam int CPU_WIDTH  = 32;
  localparam int DEF_ADDR_W = CPU_WIDTH;
  localparam int DEF_DATA_W = CPU_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  typedef enum logic {
    MST_IFU = 1'b0,
    MST_LSU = 1'b1
  } mst_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between IFU and LSU requests.
// Build option MEM_ARB_RR_EN: round-robin using the last granted master;
// otherwise fixed priority with the LSU ahead of the IFU.
module mem_arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic i_ifu_valid,
  input  logic i_lsu_valid,
`ifdef MEM_ARB_RR_EN
  input  mst_e i_last_grant,
`endif
  output logic o_any,
  output mst_e o_winner
);

  assign o_any = i_ifu_valid | i_lsu_valid;

  // Pick the winner; a lone requester always wins.
  always_comb begin
    o_winner = MST_IFU;
`ifdef MEM_ARB_RR_EN
    if (i_ifu_valid && i_lsu_valid) begin
      o_winner = (i_last_grant == MST_LSU) ? MST_IFU : MST_LSU;
    end else if (i_lsu_valid) begin
      o_winner = MST_LSU;
    end
`else
    if (i_lsu_valid) begin
      o_winner = MST_LSU;
    end
`endif
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single memory port between IFU and LSU, one transaction in
// flight at a time. Request is captured on grant and replayed to memory
// from registers; the response is routed back to the owning master.
// Build option MEM_ARB_RR_EN selects round-robin arbitration.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_rsp_valid,
  output logic [DATA_W-1:0]   ifu_rdata,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_rsp_valid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int MASK_W = DATA_W / 8;

  state_e              r_state;
  state_e              w_next;
  mst_e                r_owner;
  mst_e                w_winner;
  logic                w_any;
  logic                w_accept;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_wen;
  logic [DATA_W-1:0]   r_wdata;
  logic [MASK_W-1:0]   r_wmask;
`ifdef MEM_ARB_RR_EN
  mst_e                r_last_grant;
`endif

  mem_arb_pick u_pick (
    .i_ifu_valid  (ifu_req_valid),
    .i_lsu_valid  (lsu_req_valid),
`ifdef MEM_ARB_RR_EN
    .i_last_grant (r_last_grant),
`endif
    .o_any        (w_any),
    .o_winner     (w_winner)
  );

  assign w_accept = (r_state == ST_IDLE) && w_any;

  // State register; reset drops any outstanding transaction.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state: grant in IDLE, handshake in REQ, response in WAIT.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_any)         w_next = ST_REQ;
      ST_REQ:  if (mem_req_ready) w_next = ST_WAIT;
      ST_WAIT: if (mem_rsp_valid) w_next = ST_IDLE;
      default:                    w_next = ST_IDLE;
    endcase
  end

  // Outputs: readies only in IDLE, request in REQ, response routing in WAIT.
  always_comb begin
    ifu_req_ready = 1'b0;
    lsu_req_ready = 1'b0;
    mem_req_valid = 1'b0;
    ifu_rsp_valid = 1'b0;
    lsu_rsp_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        ifu_req_ready = w_any && (w_winner == MST_IFU);
        lsu_req_ready = w_any && (w_winner == MST_LSU);
      end
      ST_REQ: begin
        mem_req_valid = 1'b1;
      end
      ST_WAIT: begin
        ifu_rsp_valid = mem_rsp_valid && (r_owner == MST_IFU);
        lsu_rsp_valid = mem_rsp_valid && (r_owner == MST_LSU);
      end
      default: ;
    endcase
  end

  // Capture the winning request; fetches never write.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_owner <= MST_IFU;
      r_addr  <= '0;
      r_wen   <= 1'b0;
      r_wdata <= '0;
      r_wmask <= '0;
    end else if (w_accept) begin
      r_owner <= w_winner;
      if (w_winner == MST_LSU) begin
        r_addr  <= lsu_addr;
        r_wen   <= lsu_wen;
        r_wdata <= lsu_wdata;
        r_wmask <= lsu_wmask;
      end else begin
        r_addr  <= ifu_addr;
        r_wen   <= 1'b0;
        r_wdata <= '0;
        r_wmask <= '0;
      end
    end
  end

`ifdef MEM_ARB_RR_EN
  // Remember who was granted last so ties alternate.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_last_grant <= MST_IFU;
    end else if (w_accept) begin
      r_last_grant <= w_winner;
    end
  end
`endif

  assign mem_addr  = r_addr;
  assign mem_wen   = r_wen;
  assign mem_wdata = r_wdata;
  assign mem_wmask = r_wmask;
  assign ifu_rdata = mem_rdata;
  assign lsu_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed stimulus, literal expectations and a
// transaction-level reference model compared every cycle.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rsp_valid;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [3:0]  lsu_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;

  int n_tests = 0;
  int n_fail  = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rstn(rstn),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
    .ifu_addr(ifu_addr), .ifu_rsp_valid(ifu_rsp_valid), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
    .lsu_addr(lsu_addr), .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata),
    .lsu_wmask(lsu_wmask), .lsu_rsp_valid(lsu_rsp_valid), .lsu_rdata(lsu_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  // A transaction is either absent, granted-but-not-yet-taken by memory,
  // or taken and awaiting its response. Master: 0 = IFU, 1 = LSU.
  bit          m_busy, m_sent, m_owner, m_last;
  logic [31:0] m_addr, m_wdata;
  logic        m_wen;
  logic [3:0]  m_wmask;
  bit          m_grants[$];
  bit          mdl_any, mdl_win, mdl_free;

  always @(negedge clk) begin
    if (!rstn) begin
      m_busy = 0; m_sent = 0; m_owner = 0; m_last = 0;
      m_addr = '0; m_wen = 1'b0; m_wdata = '0; m_wmask = '0;
    end
    mdl_free = !m_busy;
    mdl_any  = ifu_req_valid || lsu_req_valid;
`ifdef MEM_ARB_RR_EN
    if (ifu_req_valid && lsu_req_valid) mdl_win = !m_last;
    else                                mdl_win = lsu_req_valid;
`else
    mdl_win = lsu_req_valid;
`endif
    chk("mdl_ifu_req_ready", ifu_req_ready, mdl_free && mdl_any && !mdl_win);
    chk("mdl_lsu_req_ready", lsu_req_ready, mdl_free && mdl_any && mdl_win);
    chk("mdl_mem_req_valid", mem_req_valid, m_busy && !m_sent);
    chk("mdl_mem_addr", mem_addr, m_addr);
    chk("mdl_mem_wen", mem_wen, m_wen);
    chk("mdl_mem_wdata", mem_wdata, m_wdata);
    chk("mdl_mem_wmask", mem_wmask, m_wmask);
    chk("mdl_ifu_rsp_valid", ifu_rsp_valid, m_busy && m_sent && !m_owner && mem_rsp_valid);
    chk("mdl_lsu_rsp_valid", lsu_rsp_valid, m_busy && m_sent && m_owner && mem_rsp_valid);
    if (m_busy && m_sent && mem_rsp_valid) begin
      if (!m_owner)     chk("mdl_ifu_rdata", ifu_rdata, mem_rdata);
      else if (!m_wen)  chk("mdl_lsu_rdata", lsu_rdata, mem_rdata);
    end
    if (rstn) begin
      if (mdl_free && mdl_any) begin
        m_busy = 1; m_sent = 0; m_owner = mdl_win; m_last = mdl_win;
        m_grants.push_back(mdl_win);
        if (mdl_win) begin
          m_addr = lsu_addr; m_wen = lsu_wen; m_wdata = lsu_wdata; m_wmask = lsu_wmask;
        end else begin
          m_addr = ifu_addr; m_wen = 1'b0; m_wdata = '0; m_wmask = '0;
        end
      end else if (m_busy && !m_sent && mem_req_ready) begin
        m_sent = 1;
      end else if (m_busy && m_sent && mem_rsp_valid) begin
        m_busy = 0;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic nxt;
    @(posedge clk); #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  bit dut_grants[$];
  bit exp_g[4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0;
    ifu_req_valid = 0; ifu_addr = '0;
    lsu_req_valid = 0; lsu_addr = '0; lsu_wen = 0; lsu_wdata = '0; lsu_wmask = '0;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rdata = '0;
    nxt; nxt;
    smp;
    chk("rst_mem_req_valid", mem_req_valid, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_ifu_req_ready", ifu_req_ready, 0);
    chk("rst_lsu_rsp_valid", lsu_rsp_valid, 0);
    nxt; rstn = 1'b1;
    nxt;

    // IFU-only read, minimum latency
    ifu_req_valid = 1; ifu_addr = 32'h8000_0000;
    smp; chk("t1_ifu_req_ready", ifu_req_ready, 1); chk("t1_lsu_req_ready", lsu_req_ready, 0);
    nxt; ifu_req_valid = 0; ifu_addr = '0; mem_req_ready = 1;
    smp; chk("t1_mem_req_valid", mem_req_valid, 1); chk("t1_mem_addr", mem_addr, 32'h8000_0000);
    nxt; mem_req_ready = 0; mem_rsp_valid = 1; mem_rdata = 32'h0010_0093;
    smp; chk("t1_ifu_rsp_valid", ifu_rsp_valid, 1); chk("t1_ifu_rdata", ifu_rdata, 32'h0010_0093);
    chk("t1_lsu_rsp_valid", lsu_rsp_valid, 0);
    nxt; mem_rsp_valid = 0; mem_rdata = '0;
    smp; chk("t1_rsp_pulse_end", ifu_rsp_valid, 0);
    nxt;

    // Simultaneous IFU fetch and LSU store
    ifu_req_valid = 1; ifu_addr = 32'h8000_0004;
    lsu_req_valid = 1; lsu_addr = 32'h8000_1000; lsu_wen = 1; lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hF;
    smp; chk("t2_lsu_req_ready", lsu_req_ready, 1); chk("t2_ifu_req_ready", ifu_req_ready, 0);
    nxt; lsu_req_valid = 0; lsu_wen = 0; lsu_wdata = '0; lsu_wmask = '0; lsu_addr = '0;
    mem_req_ready = 1; mem_rsp_valid = 1;
    smp; chk("t2_mem_req_valid", mem_req_valid, 1); chk("t2_mem_wen", mem_wen, 1);
    chk("t2_mem_addr", mem_addr, 32'h8000_1000); chk("t2_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("t2_mem_wmask", mem_wmask, 4'hF); chk("t2_rsp_in_req", lsu_rsp_valid, 0);
    nxt; mem_req_ready = 0; mem_rsp_valid = 0;
    smp; chk("t2_ifu_wait", ifu_req_ready, 0);
    nxt; mem_rsp_valid = 1;
    smp; chk("t2_lsu_rsp_valid", lsu_rsp_valid, 1); chk("t2_ifu_still_wait", ifu_req_ready, 0);
    nxt; mem_rsp_valid = 0;
    smp; chk("t2_ifu_granted", ifu_req_ready, 1);
    nxt; ifu_req_valid = 0; mem_req_ready = 1;
    smp; chk("t2_ifu_mem_addr", mem_addr, 32'h8000_0004); chk("t2_ifu_mem_wen", mem_wen, 0);
    chk("t2_ifu_mem_wdata", mem_wdata, 0); chk("t2_ifu_mem_wmask", mem_wmask, 0);
    nxt; mem_req_ready = 0; mem_rsp_valid = 1; mem_rdata = 32'h0000_0013;
    smp; chk("t2_ifu_rsp_valid", ifu_rsp_valid, 1); chk("t2_ifu_rdata", ifu_rdata, 32'h0000_0013);
    nxt; mem_rsp_valid = 0;

    // Memory stalls while LSU inputs wander
    lsu_req_valid = 1; lsu_addr = 32'h8000_2000; lsu_wen = 1; lsu_wdata = 32'h1234_5678; lsu_wmask = 4'h3;
    smp; chk("t3_lsu_req_ready", lsu_req_ready, 1);
    nxt;
    for (int i = 0; i < 5; i++) begin
      lsu_addr = 32'h9000_0000 + 32'(i); lsu_wdata = 32'hA5A5_0000 + 32'(i);
      mem_rsp_valid = (i == 2);
      smp;
      chk("t3_hold_addr", mem_addr, 32'h8000_2000); chk("t3_hold_wdata", mem_wdata, 32'h1234_5678);
      chk("t3_no_regrant", lsu_req_ready, 0); chk("t3_no_rsp", lsu_rsp_valid, 0);
      nxt;
    end
    lsu_req_valid = 0; mem_rsp_valid = 0; mem_req_ready = 1;
    smp; chk("t3_mem_req_valid", mem_req_valid, 1); chk("t3_wmask", mem_wmask, 4'h3);
    nxt; mem_req_ready = 0; mem_rsp_valid = 1;
    smp; chk("t3_lsu_rsp_valid", lsu_rsp_valid, 1);
    nxt; mem_rsp_valid = 0; lsu_wen = 0; lsu_addr = '0; lsu_wdata = '0; lsu_wmask = '0;

    // Spurious response in IDLE
    mem_rsp_valid = 1;
    smp; chk("t4_idle_ifu_rsp", ifu_rsp_valid, 0); chk("t4_idle_lsu_rsp", lsu_rsp_valid, 0);
    nxt; mem_rsp_valid = 0;
    smp; chk("t4_still_idle", mem_req_valid, 0);
    nxt;

    // Reset while waiting for a response
    ifu_req_valid = 1; ifu_addr = 32'h8000_0008;
    smp; nxt; ifu_req_valid = 0; mem_req_ready = 1;
    smp; nxt; mem_req_ready = 0;
    smp; chk("t5_in_wait", mem_req_valid, 0);
    nxt; rstn = 1'b0; mem_rsp_valid = 1; mem_rdata = 32'h1111_2222;
    smp; chk("t5_rst_ifu_rsp", ifu_rsp_valid, 0); chk("t5_rst_mem_req", mem_req_valid, 0);
    chk("t5_rst_mem_addr", mem_addr, 0); chk("t5_rst_ready", ifu_req_ready, 0);
    nxt; rstn = 1'b1; mem_rsp_valid = 0; mem_rdata = '0;
    smp; chk("t5_post_idle", mem_req_valid, 0);
    nxt; ifu_req_valid = 1; ifu_addr = 32'h8000_0010;
    smp; chk("t5_fresh_ready", ifu_req_ready, 1);
    nxt; ifu_req_valid = 0; mem_req_ready = 1;
    smp; chk("t5_fresh_addr", mem_addr, 32'h8000_0010);
    nxt; mem_req_ready = 0; mem_rsp_valid = 1; mem_rdata = 32'hCAFE_F00D;
    smp; chk("t5_fresh_rsp", ifu_rsp_valid, 1); chk("t5_fresh_rdata", ifu_rdata, 32'hCAFE_F00D);
    nxt; mem_rsp_valid = 0;

    // Both masters requesting continuously for four transactions
    m_grants.delete();
    ifu_req_valid = 1; ifu_addr = 32'h8000_0020;
    lsu_req_valid = 1; lsu_addr = 32'h8000_3000; lsu_wen = 0;
    mem_req_ready = 1; mem_rsp_valid = 1; mem_rdata = 32'h55AA_55AA;
    for (int i = 0; i < 12; i++) begin
      smp;
      if (lsu_req_ready)      dut_grants.push_back(1'b1);
      else if (ifu_req_ready) dut_grants.push_back(1'b0);
      nxt;
    end
    ifu_req_valid = 0; lsu_req_valid = 0; mem_req_ready = 0; mem_rsp_valid = 0;
`ifdef MEM_ARB_RR_EN
    exp_g[0] = 1; exp_g[1] = 0; exp_g[2] = 1; exp_g[3] = 0;
`else
    exp_g[0] = 1; exp_g[1] = 1; exp_g[2] = 1; exp_g[3] = 1;
`endif
    chk("t6_dut_grant_count", dut_grants.size(), 4);
    chk("t6_mdl_grant_count", m_grants.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < dut_grants.size()) chk("t6_dut_grant_order", dut_grants[i], exp_g[i]);
      if (i < m_grants.size())   chk("t6_mdl_grant_order", m_grants[i], exp_g[i]);
    end
    smp; nxt; smp;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
